// File: rtl/nios2_mul_pkg.sv
// Shared types and widths for the MUL/MULX sequencer and combiner.
// Optional high-word support is selected with MUL_HIGH_EN.
package nios2_mul_pkg;

    localparam int MUL_W    = 32;
    localparam int MUL_HALF = 16;
    localparam int T_W      = 49;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SUM,
        S_HIGH,
        S_DONE
    } mul_state_e;

endpackage

// File: rtl/nios2_mul_sign_fix.sv
// Signed correction of the unsigned 32x32 high word (MULXSU / MULXSS).
// Only instantiated when MUL_HIGH_EN is defined.
module nios2_mul_sign_fix
    import nios2_mul_pkg::*;
(
    input  logic [MUL_W-1:0] i_high,
    input  logic [MUL_W-1:0] i_a,
    input  logic [MUL_W-1:0] i_b,
    input  mul_op_e          i_op,
    output logic [MUL_W-1:0] o_high
);

    logic             w_a_signed;
    logic             w_b_signed;
    logic [MUL_W-1:0] w_sub_b;
    logic [MUL_W-1:0] w_sub_a;

    assign w_a_signed = (i_op == OP_MULXSU) || (i_op == OP_MULXSS);
    assign w_b_signed = (i_op == OP_MULXSS);

    // A negative two's-complement operand contributes -2^32 * other.
    assign w_sub_b = (w_a_signed && i_a[MUL_W-1]) ? i_b : '0;
    assign w_sub_a = (w_b_signed && i_b[MUL_W-1]) ? i_a : '0;

    assign o_high = i_high - w_sub_b - w_sub_a;

endmodule

// File: rtl/nios2_cpu_mul_combine.sv
// Multiply sequencer/combiner behind the 16x16 partial-product cell.
// MUL_HIGH_EN enables the MULX high-word second pass.
module nios2_cpu_mul_combine
    import nios2_mul_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [MUL_W-1:0] req_a,
    input  logic [MUL_W-1:0] req_b,
    output logic [MUL_W-1:0] mul_src1,
    output logic [MUL_W-1:0] mul_src2,
    output logic             mul_en,
    input  logic [MUL_W-1:0] mul_cell_p1,
    input  logic [MUL_W-1:0] mul_cell_p2,
    input  logic [MUL_W-1:0] mul_cell_p3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MUL_W-1:0] rsp_result,
    output logic             rsp_unimp
);

    mul_state_e       r_state;
    mul_state_e       w_next;
    mul_op_e          r_op;
    logic [MUL_W-1:0] r_a;
    logic [MUL_W-1:0] r_b;
    logic [T_W-1:0]   r_t;
    logic [MUL_W-1:0] r_result;
    logic             r_unimp;

    logic [MUL_W:0]   w_mid;
    logic [T_W-1:0]   w_t;
    logic             w_is_mul;

    assign w_mid    = {1'b0, mul_cell_p2} + {1'b0, mul_cell_p3};
    assign w_t      = {17'b0, mul_cell_p1} + {w_mid, 16'b0};
    assign w_is_mul = (r_op == OP_MUL);

`ifdef MUL_HIGH_EN
    logic [MUL_W-1:0] w_high_u;
    logic [MUL_W-1:0] w_high_fix;

    // p1 holds a.hi*b.hi during HIGH; add the carry-out of the low fold.
    assign w_high_u = mul_cell_p1 + {15'b0, r_t[T_W-1:MUL_W]};

    nios2_mul_sign_fix u_sign_fix (
        .i_high (w_high_u),
        .i_a    (r_a),
        .i_b    (r_b),
        .i_op   (r_op),
        .o_high (w_high_fix)
    );
`endif

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mul_en    = 1'b0;
        mul_src1  = '0;
        mul_src2  = '0;
        rsp_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                mul_en   = 1'b1;
                mul_src1 = r_a;
                mul_src2 = r_b;
                w_next   = S_SUM;
            end
            S_SUM: begin
`ifdef MUL_HIGH_EN
                if (w_is_mul) begin
                    w_next = S_DONE;
                end else begin
                    mul_en   = 1'b1;
                    mul_src1 = {16'b0, r_a[MUL_W-1:MUL_HALF]};
                    mul_src2 = {16'b0, r_b[MUL_W-1:MUL_HALF]};
                    w_next   = S_HIGH;
                end
`else
                w_next = S_DONE;
`endif
            end
            S_HIGH: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_t      <= '0;
            r_result <= '0;
            r_unimp  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_a  <= req_a;
                r_b  <= req_b;
                r_op <= mul_op_e'(req_op);
            end
            if (r_state == S_SUM) begin
                r_t <= w_t;
`ifdef MUL_HIGH_EN
                if (w_is_mul) r_result <= w_t[MUL_W-1:0];
                r_unimp <= 1'b0;
`else
                r_result <= w_is_mul ? w_t[MUL_W-1:0] : '0;
                r_unimp  <= !w_is_mul;
`endif
            end
`ifdef MUL_HIGH_EN
            if (r_state == S_HIGH) r_result <= w_high_fix;
`endif
        end
    end

    assign rsp_result = r_result;
    assign rsp_unimp  = r_unimp;

endmodule

// File: tb/tb_nios2_cpu_mul_combine.sv
// Bench for nios2_cpu_mul_combine: vector table, random ops vs model,
// backpressure and mid-flight reset. Honours MUL_HIGH_EN.
module tb_nios2_cpu_mul_combine;

`ifdef MUL_HIGH_EN
    localparam bit HI = 1'b1;
`else
    localparam bit HI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic        mul_en;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    logic [31:0] p3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_unimp;

    int n_tests = 0;
    int n_fail  = 0;

    nios2_cpu_mul_combine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_src1    (mul_src1),
        .mul_src2    (mul_src2),
        .mul_en      (mul_en),
        .mul_cell_p1 (p1),
        .mul_cell_p2 (p2),
        .mul_cell_p3 (p3),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_unimp   (rsp_unimp)
    );

    always #5 clk = ~clk;

    // Multiply cell: products registered one edge after mul_en.
    always @(posedge clk) begin
        if (mul_en) begin
            p1 <= {16'b0, mul_src1[15:0]} * {16'b0, mul_src2[15:0]};
            p2 <= {16'b0, mul_src1[15:0]} * {16'b0, mul_src2[31:16]};
            p3 <= {16'b0, mul_src1[31:16]} * {16'b0, mul_src2[15:0]};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic void ref_mul(input logic [1:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] r,
                                    output logic un);
        logic [63:0]        p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        un = 1'b0;
        case (op)
            2'd0:    p = {32'b0, a} * {32'b0, b};
            2'd1:    p = {32'b0, a} * {32'b0, b};
            2'd2:    p = sa * ub;
            default: p = sa * sb;
        endcase
        r = (op == 2'd0) ? p[31:0] : p[63:32];
        if (!HI && op != 2'd0) begin
            r  = '0;
            un = 1'b1;
        end
    endfunction

    // Issue one op, wait for the response, hold it `hold` cycles, take it.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         output logic [31:0] res, output logic un,
                         output int lat, output int en_cnt);
        int cyc;
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc    = 1;
        en_cnt = 0;
        while (!rsp_valid && cyc < 20) begin
            if (mul_en) en_cnt++;
            chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
        res = rsp_result;
        un  = rsp_unimp;
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_result", rsp_result, res);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
            chk("hold_mul_en", {31'b0, mul_en}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("back_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("back_idle_valid", {31'b0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [31:0] res;
        logic [31:0] eres;
        logic        un;
        logic        eun;
        int          lat;
        int          en;
        int          seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0] = '{2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
        vt[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vt[2] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vt[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[4] = '{2'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vt[5] = '{2'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
        vt[6] = '{2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vt[7] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
        vt[8] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_mul_en", {31'b0, mul_en}, 32'd0);
        chk("rst_src1", mul_src1, 32'd0);
        chk("rst_src2", mul_src2, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_unimp", {31'b0, rsp_unimp}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, 0, res, un, lat, en);
            eun = (!HI && vt[i].op != 2'd0);
            chk($sformatf("vec%0d_result", i), res, eun ? 32'd0 : vt[i].exp);
            chk($sformatf("vec%0d_unimp", i), {31'b0, un}, {31'b0, eun});
            chk($sformatf("vec%0d_latency", i), lat,
                (HI && vt[i].op != 2'd0) ? 4 : 3);
            chk($sformatf("vec%0d_mul_en_cycles", i), en,
                (HI && vt[i].op != 2'd0) ? 2 : 1);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 5 == 0) ra[31] = 1'b1;
            do_op(rop, ra, rb, $urandom_range(0, 2), res, un, lat, en);
            ref_mul(rop, ra, rb, eres, eun);
            chk($sformatf("rnd%0d_op%0d_result", i, rop), res, eres);
            chk($sformatf("rnd%0d_unimp", i), {31'b0, un}, {31'b0, eun});
            chk($sformatf("rnd%0d_latency", i), lat,
                (HI && rop != 2'd0) ? 4 : 3);
        end

        do_op(2'd0, 32'h0001_0003, 32'h0002_0005, 5, res, un, lat, en);
        chk("bp_result", res, 32'h000B_000F);

        req_valid = 1'b1;
        req_op    = 2'd1;
        req_a     = 32'hFFFF_FFFF;
        req_b     = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (HI ? 2 : 1) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("inflight_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("inflight_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("inflight_rst_mul_en", {31'b0, mul_en}, 32'd0);
        chk("inflight_rst_result", rsp_result, 32'd0);
        chk("inflight_rst_unimp", {31'b0, rsp_unimp}, 32'd0);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("inflight_no_rsp", seen, 0);
        do_op(2'd0, 32'd3, 32'd5, 0, res, un, lat, en);
        chk("post_rst_result", res, 32'h0000_000F);
        chk("post_rst_latency", lat, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
